lut_tt_capture: RTL and testbench

LUT_TT_CAPTURE -- requirements
Module: lut_tt_capture

---
 rtl/lut_tt_pkg.sv | 18 +
 rtl/lut_tt_capture_settle_timer.sv | 27 ++
 rtl/lut_tt_capture.sv | 80 ++++++++
 tb/tb_lut_tt_capture.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/lut_tt_pkg.sv
// Shared types and sizes for the LUT truth-table capture block.
package lut_tt_pkg;

  localparam int PAT_W    = 4;
  localparam int TT_DEPTH = 16;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  // A counter that only ever holds 0 still needs one bit.
  function automatic int settle_cnt_width(input int settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

endpackage

// File: rtl/lut_tt_capture_settle_timer.sv
// Settle counter: counts enabled cycles and wraps to zero after SETTLE of them.
module settle_timer
  import lut_tt_pkg::*;
#(
  parameter int SETTLE = 1,
  localparam int W = settle_cnt_width(SETTLE)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  assign tc = en && (count == W'(SETTLE - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en) begin
      if (tc) count <= '0;
      else    count <= count + W'(1);
    end
  end

endmodule

// File: rtl/lut_tt_capture.sv
// Sweeps x_out over all 16 patterns, samples y_in into truth_table after SETTLE cycles each.
// Optional macro LUT_TT_COMPARE_EN adds the registered compare against the latched expected table.
module lut_tt_capture
  import lut_tt_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [PAT_W-1:0]    x_out,
  input  logic                y_in,
  input  logic [TT_DEPTH-1:0] expected,
  output logic                busy,
  output logic                done,
  output logic [TT_DEPTH-1:0] truth_table,
  output logic                pass
);

  localparam int CNT_W = settle_cnt_width(SETTLE);

  state_t           state;
  logic             accept;
  logic             sample;
  logic             last_pat;
  logic [CNT_W-1:0] unused_count;

  assign accept   = start && (state != RUN);
  assign last_pat = (x_out == PAT_W'(TT_DEPTH - 1));
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .en    (busy),
    .count (unused_count),
    .tc    (sample)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      x_out       <= '0;
      truth_table <= '0;
    end else if (accept) begin
      state       <= RUN;
      x_out       <= '0;
      truth_table <= '0;
    end else if (busy && sample) begin
      truth_table[x_out] <= y_in;
      if (last_pat) state <= DONE;
      else          x_out <= x_out + PAT_W'(1);
    end
  end

`ifdef LUT_TT_COMPARE_EN
  logic [TT_DEPTH-1:0] exp_q;

  // Bit 15 is still being written on the final sample, so splice y_in in for the compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      pass  <= 1'b0;
      exp_q <= '0;
    end else if (accept) begin
      pass  <= 1'b0;
      exp_q <= expected;
    end else if (busy && sample && last_pat) begin
      pass <= ({y_in, truth_table[TT_DEPTH-2:0]} == exp_q);
    end
  end
`else
  logic unused_expected;

  assign unused_expected = ^expected;
  assign pass            = 1'b0;
`endif

endmodule

// File: tb/tb_lut_tt_capture.sv
// Self-checking bench: two instances (SETTLE=1 and SETTLE=3) against a cycle-count based model.
module tb_lut_tt_capture;

`ifdef LUT_TT_COMPARE_EN
  localparam bit CMP_EN = 1'b1;
`else
  localparam bit CMP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] expected;
  logic [15:0] lut_table;

  logic [3:0]  x_a, x_b;
  logic        y_a, y_b;
  logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [15:0] tt_a, tt_b;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  assign y_a = lut_table[x_a];
  assign y_b = lut_table[x_b];

  lut_tt_capture #(.SETTLE(1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .x_out(x_a), .y_in(y_a),
    .expected(expected), .busy(busy_a), .done(done_a),
    .truth_table(tt_a), .pass(pass_a)
  );

  lut_tt_capture #(.SETTLE(3)) dut_b (
    .clk(clk), .rst(rst), .start(start), .x_out(x_b), .y_in(y_b),
    .expected(expected), .busy(busy_b), .done(done_b),
    .truth_table(tt_b), .pass(pass_b)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errs++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // Model: a sweep is just a count k of RUN cycles; pattern = k/S, sample when k%S == S-1.
  int          settle_of [2] = '{1, 3};
  bit          m_active  [2];
  int          m_k       [2];
  bit          m_done    [2];
  bit          m_pass    [2];
  logic [15:0] m_tt      [2];
  logic [15:0] m_exp     [2];
  logic [3:0]  m_hold    [2];

  task automatic model_step(input int i);
    int s;
    s = settle_of[i];
    if (rst) begin
      m_active[i] = 0; m_k[i] = 0; m_done[i] = 0; m_pass[i] = 0;
      m_tt[i] = '0; m_hold[i] = '0;
    end else if (start && !m_active[i]) begin
      m_active[i] = 1; m_k[i] = 0; m_done[i] = 0; m_pass[i] = 0;
      m_tt[i] = '0; m_exp[i] = expected;
    end else if (m_active[i]) begin
      if (m_k[i] % s == s - 1) m_tt[i][m_k[i] / s] = lut_table[m_k[i] / s];
      m_k[i]++;
      if (m_k[i] == 16 * s) begin
        m_active[i] = 0;
        m_done[i]   = 1;
        m_hold[i]   = 4'd15;
        m_pass[i]   = CMP_EN && (m_tt[i] == m_exp[i]);
      end
    end
  endtask

  function automatic logic [3:0] model_x(input int i);
    return m_active[i] ? 4'(m_k[i] / settle_of[i]) : m_hold[i];
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 0; m_k[i] = 0; m_done[i] = 0; m_pass[i] = 0;
      m_tt[i] = '0; m_exp[i] = '0; m_hold[i] = '0;
    end
  end

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    #1;
    check_output("A.busy",  32'(busy_a), 32'(m_active[0]));
    check_output("A.done",  32'(done_a), 32'(m_done[0]));
    check_output("A.x_out", 32'(x_a),    32'(model_x(0)));
    check_output("A.tt",    32'(tt_a),   32'(m_tt[0]));
    check_output("A.pass",  32'(pass_a), 32'(m_pass[0]));
    check_output("B.busy",  32'(busy_b), 32'(m_active[1]));
    check_output("B.done",  32'(done_b), 32'(m_done[1]));
    check_output("B.x_out", 32'(x_b),    32'(model_x(1)));
    check_output("B.tt",    32'(tt_b),   32'(m_tt[1]));
    check_output("B.pass",  32'(pass_b), 32'(m_pass[1]));
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns just after the accepting edge, so outputs already reflect the first RUN cycle.
  task automatic apply_stimulus(input logic [15:0] lut, input logic [15:0] exp_tt);
    lut_table = lut;
    expected  = exp_tt;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; expected = '0; lut_table = 16'h6996;
    wait_cycles(2);
    rst = 1'b0;
    check_output("reset.busy",  32'(busy_a), 32'h0);
    check_output("reset.done",  32'(done_a), 32'h0);
    check_output("reset.x_out", 32'(x_a),    32'h0);
    check_output("reset.tt",    32'(tt_b),   32'h0);
    check_output("reset.pass",  32'(pass_b), 32'h0);

    // Parity LUT, SETTLE=1: done must rise on the 17th edge counting the accepting one.
    apply_stimulus(16'h6996, 16'h6996);
    check_output("xor.busy_start", 32'(busy_a), 32'h1);
    wait_cycles(15);
    check_output("xor.done_e16", 32'(done_a), 32'h0);
    check_output("xor.busy_e16", 32'(busy_a), 32'h1);
    wait_cycles(1);
    check_output("xor.done_e17", 32'(done_a), 32'h1);
    check_output("xor.busy_e17", 32'(busy_a), 32'h0);
    check_output("xor.tt_a",     32'(tt_a),   32'h6996);
    check_output("xor.pass_a",   32'(pass_a), 32'(CMP_EN));
    wait_cycles(31);
    check_output("xor.busy_b47", 32'(busy_b), 32'h1);
    wait_cycles(1);
    check_output("xor.done_b",   32'(done_b), 32'h1);
    check_output("xor.tt_b",     32'(tt_b),   32'h6996);

    // AND LUT, SETTLE=3.
    apply_stimulus(16'h8000, 16'h8000);
    wait_cycles(48);
    check_output("and.tt_b",   32'(tt_b),   32'h8000);
    check_output("and.pass_b", 32'(pass_b), 32'(CMP_EN));
    check_output("and.done_b", 32'(done_b), 32'h1);

    // OR LUT against all-ones reference: x=0 gives 0, so compare must fail.
    apply_stimulus(16'hFFFE, 16'hFFFF);
    wait_cycles(48);
    check_output("or.tt_b",   32'(tt_b),   32'hFFFE);
    check_output("or.pass_b", 32'(pass_b), 32'h0);
    check_output("or.pass_a", 32'(pass_a), 32'h0);

    // Reset mid-sweep at pattern 7.
    apply_stimulus(16'h6996, 16'h6996);
    wait_cycles(7);
    check_output("rst.x_before", 32'(x_a), 32'h7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("rst.x_a",    32'(x_a),    32'h0);
    check_output("rst.busy_a", 32'(busy_a), 32'h0);
    check_output("rst.tt_a",   32'(tt_a),   32'h0);
    check_output("rst.done_b", 32'(done_b), 32'h0);
    apply_stimulus(16'h6996, 16'h6996);
    wait_cycles(48);
    check_output("rst.resweep_a", 32'(tt_a), 32'h6996);
    check_output("rst.resweep_b", 32'(tt_b), 32'h6996);

    // Restart during RUN is ignored; restart in DONE begins a fresh sweep.
    apply_stimulus(16'h6996, 16'h6996);
    wait_cycles(5);
    check_output("rerun.x_a5", 32'(x_a), 32'h5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cycles(9);
    check_output("rerun.done_e16", 32'(done_a), 32'h0);
    wait_cycles(1);
    check_output("rerun.done_e17", 32'(done_a), 32'h1);
    wait_cycles(32);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_output("redone.done_a", 32'(done_a), 32'h0);
    check_output("redone.busy_a", 32'(busy_a), 32'h1);
    check_output("redone.x_a",    32'(x_a),    32'h0);
    wait_cycles(48);

    // Random tables, random mid-sweep start pulses, expected churned during RUN.
    for (int it = 0; it < 8; it++) begin
      apply_stimulus(16'($urandom), 16'($urandom));
      if ($urandom_range(0, 1) == 1) expected = lut_table;
      for (int c = 0; c < 52; c++) begin
        if ($urandom_range(0, 15) == 0) start = 1'b1;
        if (it == 5 && c == 20) rst = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        rst      = 1'b0;
        expected = 16'($urandom);
      end
    end

    wait_cycles(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
    $finish;
  end

endmodule
